// File: rtl/tb_regbus_memory.sv
// Register-bus memory slave: word-addressed, byte-writable storage with a
// registered single-wait-state response.
// Optional feature macro: TB_REGBUS_MEM_ERR_EN. When it is defined, out-of-range
// accesses return rsp_error_o = 1. When it is undefined, rsp_error_o stays 0.
//
// state | meaning
// IDLE  | waiting for req_valid_i; the access is performed on the accept edge
// RESP  | rsp_ready_o high for one cycle, then always back to IDLE
module tb_regbus_memory #(
  parameter int AddrWidth = 48,
  parameter int DataWidth = 32,
  parameter int Depth = 256,
  parameter logic [AddrWidth-1:0] BaseAddr = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_wstrb_i,
  input  logic                   req_valid_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   rsp_ready_o
);

  localparam int NumBytes = DataWidth / 8;
  localparam int OffW = $clog2(NumBytes);
  localparam int IdxW = $clog2(Depth);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];

  logic [AddrWidth-1:0] off;
  logic [AddrWidth-1:0] idx;
  logic [IdxW-1:0]      idx_w;
  logic                 in_range;

  // Address decode; a wrapped subtraction is caught by the explicit lower-bound compare.
  always_comb begin
    off      = req_addr_i - BaseAddr;
    idx      = off >> OffW;
    idx_w    = idx[IdxW-1:0];
    in_range = (req_addr_i >= BaseAddr) && (idx < AddrWidth'(Depth));
  end

  // Next state, response capture and storage update on accept.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = RESP;
          rdata_d = '0;
`ifdef TB_REGBUS_MEM_ERR_EN
          error_d = !in_range;
`else
          error_d = 1'b0;
`endif
          if (in_range) begin
            if (req_write_i) begin
              for (int b = 0; b < NumBytes; b++) begin
                if (req_wstrb_i[b]) begin
                  mem_d[idx_w][b*8 +: 8] = req_wdata_i[b*8 +: 8];
                end
              end
            end else begin
              rdata_d = mem_q[idx_w];
            end
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, response and storage registers; reset clears everything including storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      mem_q   <= mem_d;
    end
  end

  assign rsp_ready_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;

endmodule

// File: tb/tb_tb_regbus_memory.sv
// Scoreboard bench for tb_regbus_memory (BaseAddr = 0x1000, Depth = 256).
module tb_tb_regbus_memory;

`ifdef TB_REGBUS_MEM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] addr = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        valid = 1'b0;
  logic [31:0] rdata;
  logic        err;
  logic        ready;

  int total = 0;
  int passed = 0;
  logic [32:0] exp_q [$];
  logic        prev_ready = 1'b0;

  tb_regbus_memory #(
    .AddrWidth(48),
    .DataWidth(32),
    .Depth(256),
    .BaseAddr(48'h1000)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_addr_i(addr),
    .req_write_i(wr),
    .req_wdata_i(wdata),
    .req_wstrb_i(wstrb),
    .req_valid_i(valid),
    .rsp_rdata_o(rdata),
    .rsp_error_o(err),
    .rsp_ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every response is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 33'(1), 33'(0));
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", {1'b0, rdata}, {1'b0, e[31:0]});
        check("rsp_error", {32'b0, err}, {32'b0, e[32]});
      end
      if (prev_ready) check("ready_back_to_back", 33'(1), 33'(0));
    end
    prev_ready <= ready;
  end

  task automatic access(input logic [47:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err);
    int cyc;
    @(negedge clk);
    addr  = a;
    wr    = w;
    wdata = d;
    wstrb = s;
    valid = 1'b1;
    exp_q.push_back({exp_err, exp_rd});
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready && cyc < 6);
    check("latency", 33'(cyc), 33'(1));
    valid = 1'b0;
  endtask

  initial begin
    #12;
    check("reset_ready", {32'b0, ready}, 33'(0));
    check("reset_rdata", {1'b0, rdata}, 33'(0));
    check("reset_error", {32'b0, err}, 33'(0));
    @(negedge clk);
    rst = 1'b0;

    access(48'h1000, 1'b0, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    access(48'h1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    access(48'h1004, 1'b1, 32'h0000_0011, 4'h1, 32'h0, 1'b0);
    access(48'h1004, 1'b0, 32'h0, 4'h0, 32'hDEAD_BE11, 1'b0);
    access(48'h1004, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    access(48'h1004, 1'b0, 32'h0, 4'h0, 32'hDEAD_BE11, 1'b0);
    access(48'h1004, 1'b1, 32'h00CA_FE00, 4'h6, 32'h0, 1'b0);
    access(48'h1007, 1'b0, 32'h0, 4'h0, 32'hDECA_FE11, 1'b0);
    access(48'h13FC, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
    access(48'h13FC, 1'b0, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0);
    access(48'h1400, 1'b0, 32'h0, 4'h0, 32'h0, ErrEn);
    access(48'h0FFC, 1'b0, 32'h0, 4'h0, 32'h0, ErrEn);
    access(48'h1400, 1'b1, 32'h5555_5555, 4'hF, 32'h0, ErrEn);
    access(48'h1000, 1'b0, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    access(48'h13FC, 1'b0, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0);

    // Valid held continuously: ready on every odd cycle only.
    @(negedge clk);
    addr  = 48'h13FC;
    wr    = 1'b0;
    valid = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 32'hA5A5_A5A5});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("held_ready_pattern", {32'b0, ready}, {32'b0, 1'(k % 2)});
    end
    valid = 1'b0;

    // Reset during RESP: response lost, outputs clear without a clock edge, storage cleared.
    @(negedge clk);
    addr  = 48'h1008;
    wr    = 1'b1;
    wdata = 32'h1234_5678;
    wstrb = 4'hF;
    valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_ready", {32'b0, ready}, 33'(0));
    check("async_reset_rdata", {1'b0, rdata}, 33'(0));
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b0;
    access(48'h1008, 1'b0, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    access(48'h13FC, 1'b0, 32'h0, 4'h0, 32'h0000_0000, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 33'(exp_q.size()), 33'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
